// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: controller states and slice width.
package sub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub4_slice.sv
// Combinational 4-bit ripple-borrow subtractor slice: D = A - B - bin, bout = borrow out.
module sub4_slice
  import sub_pkg::*;
(
  input  logic               bin,
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  output logic [SLICE_W-1:0] D,
  output logic               bout
);

  logic [SLICE_W:0] br;

  always_comb begin
    br    = '0;
    D     = '0;
    br[0] = bin;
    for (int i = 0; i < SLICE_W; i++) begin
      D[i]    = A[i] ^ B[i] ^ br[i];
      br[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & br[i]);
    end
  end

  assign bout = br[SLICE_W];

endmodule

// File: rtl/multiword_sub_ctrl.sv
// Nibble-serial multiword subtractor: captures A/B/bin, runs one shared 4-bit slice per cycle,
// and presents D/bout with a valid/ready handshake.
module multiword_sub_ctrl
  import sub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SLICE_W*NIBBLES-1:0] A,
  input  logic [SLICE_W*NIBBLES-1:0] B,
  input  logic                   bin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SLICE_W*NIBBLES-1:0] D,
  output logic                   bout,
  output logic                   busy
);

  localparam int W  = SLICE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           br_q, br_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   d_q, d_d;
  logic           bout_q, bout_d;

  logic [SLICE_W-1:0] a_nib, b_nib, d_nib;
  logic               nib_bout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)            state_d = RUN;
      RUN:     if (cnt_q == LAST_CNT)   state_d = DONE;
      DONE:    if (out_ready)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Steer the current nibble of the captured operands into the single shared slice.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (cnt_q == CW'(n)) begin
        a_nib = a_q[n*SLICE_W +: SLICE_W];
        b_nib = b_q[n*SLICE_W +: SLICE_W];
      end
    end
  end

  sub4_slice u_slice (
    .bin  (br_q),
    .A    (a_nib),
    .B    (b_nib),
    .D    (d_nib),
    .bout (nib_bout)
  );

  always_comb begin
    cnt_d  = cnt_q;
    br_d   = br_q;
    a_d    = a_q;
    b_d    = b_q;
    d_d    = d_q;
    bout_d = bout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = A;
          b_d   = B;
          br_d  = bin;
          cnt_d = '0;
        end
      end
      RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (cnt_q == CW'(n)) begin
            d_d[n*SLICE_W +: SLICE_W] = d_nib;
          end
        end
        br_d = nib_bout;
        if (cnt_q == LAST_CNT) begin
          bout_d = nib_bout;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      br_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      br_q   <= br_d;
      a_q    <= a_d;
      b_q    <= b_d;
      d_q    <= d_d;
      bout_q <= bout_d;
    end
  end

  assign D    = d_q;
  assign bout = bout_q;

endmodule

// File: doc/multiword_sub_ctrl.md
MULTIWORD_SUB_CTRL -- requirements
Module: multiword_sub_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning the number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 SHALL have port A, input, W bits: the minuend.
REQ-007 SHALL have port B, input, W bits: the subtrahend.
REQ-008 SHALL have port bin, input, 1 bit: the borrow-in to the least significant nibble.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port D, output, W bits: the difference A-B-bin modulo 2^W.
REQ-012 SHALL have port bout, output, 1 bit: the borrow out of the most significant nibble.
REQ-013 SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-014 SHALL implement exactly three states: IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready = (state==IDLE) combinationally, with no dependence on in_valid.
REQ-016 SHALL, in IDLE when in_valid && in_ready, capture A, B and bin into internal registers, clear nibble counter cnt to 0, and go to RUN.
REQ-017 SHALL, in RUN, apply nibble cnt of the captured A and B plus the borrow register to one shared 4-bit ripple-borrow slice each cycle, write the 4-bit result into D[4*cnt+3:4*cnt], load the slice borrow-out into the borrow register, and increment cnt.
REQ-018 SHALL use bin itself as the borrow register's value for cnt=0.
REQ-019 SHALL, when cnt==NIBBLES-1 in RUN, go to DONE on the same edge that writes the final nibble, and load bout from the final borrow-out.
REQ-020 SHALL make accept-to-out_valid latency exactly NIBBLES cycles: accept at edge k, out_valid high after edge k+NIBBLES.
REQ-021 SHALL hold out_valid=1 in DONE, keeping D and bout stable until out_ready=1 is sampled, then return to IDLE.
REQ-022 SHALL NOT accept a new operand on the edge that completes a DONE handshake, since in_ready=0 in DONE; back-to-back throughput is one result per NIBBLES+2 cycles when out_ready is held high.
REQ-023 SHALL ignore changes on A, B and bin after capture; in_valid is a don't-care outside IDLE.
REQ-024 SHALL apply slice equations per bit i: d_i = a_i ^ b_i ^ br_i and br_(i+1) = (~a_i & b_i) | (~(a_i ^ b_i) & br_i).
REQ-025 SHALL size cnt to $clog2(NIBBLES) bits (minimum 1 bit), with no wrap-around beyond NIBBLES-1.
REQ-026 SHALL hold D and bout at their last values while the block is in IDLE.

Reset
REQ-027 SHALL, on rst_n=0 asynchronously, force state=IDLE, cnt=0, the borrow register to 0, D=0, bout=0, out_valid=0 and busy=0, with in_ready=1.
REQ-028 SHALL, when reset is asserted during RUN or DONE, abandon the operation and emit no partial result after release.
REQ-029 SHALL become able to accept a new operand on the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL place the state encoding (IDLE/RUN/DONE) and the slice width constant (4) in shared package sub_pkg.
REQ-031 SHALL instantiate exactly one combinational sub-module, sub4_slice (ports: bin, A[3:0], B[3:0], D[3:0], bout), for every nibble.
REQ-032 SHALL keep all sequencing and nibble steering in multiword_sub_ctrl.

Verification
REQ-033 SHALL cover: A=0x1234, B=0x0234, bin=0 -> D=0x1000 and bout=0, with out_valid rising exactly 4 cycles after accept.
REQ-034 SHALL cover: A=0x0000, B=0x0001, bin=0 -> D=0xFFFF and bout=1, with the borrow rippling through all 4 nibbles.
REQ-035 SHALL cover: A=0x0005, B=0x0005, bin=1 -> D=0xFFFF and bout=1.
REQ-036 SHALL cover: A=0x8000, B=0x0001, out_ready held 0 for 5 cycles -> D=0x7FFF and bout=0 stay stable, out_valid stays 1, and in_ready stays 0 until the handshake.
REQ-037 SHALL cover: rst_n pulsed low at cnt=2 of a RUN -> immediately state=IDLE, D=0 and out_valid=0; the next op A=0x0010, B=0x0001 -> D=0x000F.
REQ-038 SHALL cover: two back-to-back ops with out_ready=1 and in_valid held high -> two correct results 6 cycles apart, with A/B changed mid-RUN having no effect.
